// File: rtl/pixel_packer_mono8_if.sv
// Stream and block-control bundle for the Mono8 pixel packer.
// The slave modport is the packer's view; master is the driver/observer side.
interface pixel_packer_mono8_if;
    logic         ap_start;
    logic         ap_done;
    logic         ap_ready;
    logic         ap_idle;
    logic         s_axis_tvalid;
    logic         s_axis_tready;
    logic [7:0]   s_axis_tdata;
    logic         m_axis_tvalid;
    logic         m_axis_tready;
    logic [255:0] m_axis_tdata;
    logic [31:0]  m_axis_tkeep;
    logic         m_axis_tlast;

    modport slave (
        input  ap_start, s_axis_tvalid, s_axis_tdata, m_axis_tready,
        output ap_done, ap_ready, ap_idle, s_axis_tready,
               m_axis_tvalid, m_axis_tdata, m_axis_tkeep, m_axis_tlast
    );

    modport master (
        output ap_start, s_axis_tvalid, s_axis_tdata, m_axis_tready,
        input  ap_done, ap_ready, ap_idle, s_axis_tready,
               m_axis_tvalid, m_axis_tdata, m_axis_tkeep, m_axis_tlast
    );
endinterface

// File: rtl/pixel_packer_mono8.sv
// Packs 32 Mono8 pixels (first pixel in byte 0) into one 256-bit AXI-Stream word,
// frame-aware with tkeep-qualified zero-padded final word and tlast.
module pixel_packer_mono8 #(
    parameter int OUT_ROWS = 20,
    parameter int OUT_COLS = 20
) (
    input  logic                    clk,
    input  logic                    s_axis_resetn,
    pixel_packer_mono8_if.slave     bus
);
    localparam int N     = OUT_ROWS * OUT_COLS;
    localparam int R     = N % 32;
    localparam int IDX_W = (N > 1) ? $clog2(N + 1) : 1;

    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(N - 1);
    localparam logic [31:0]      KEEP_LAST = (R == 0) ? 32'hFFFF_FFFF : ((32'd1 << R) - 32'd1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] PACK = 2'd1;
    localparam logic [1:0] SEND = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    logic [1:0]       state;
    logic [255:0]     pack_reg;
    logic [4:0]       cnt_idx_in_word;
    logic [IDX_W-1:0] cnt_idx_in_frame;
    logic             last_word;

    logic s_hs;
    logic word_full;
    logic frame_end;

    assign s_hs      = bus.s_axis_tvalid && (state == PACK);
    assign word_full = (cnt_idx_in_word == 5'd31);
    assign frame_end = (cnt_idx_in_frame == LAST_IDX);

    // NOTE: every register below uses non-blocking assignment so all state updates
    // see the same pre-edge values; blocking here would create ordering-dependent logic.
    always_ff @(posedge clk or negedge s_axis_resetn) begin
        if (!s_axis_resetn) begin
            state            <= IDLE;
            // NOTE: the pack register is reset (not left undefined) because its
            // contents drive m_axis_tdata directly and padding bytes must read as 0.
            pack_reg         <= '0;
            cnt_idx_in_word  <= '0;
            cnt_idx_in_frame <= '0;
            last_word        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.ap_start) begin
                        pack_reg         <= '0;
                        cnt_idx_in_word  <= '0;
                        cnt_idx_in_frame <= '0;
                        last_word        <= 1'b0;
                        state            <= PACK;
                    end
                end
                PACK: begin
                    if (s_hs) begin
                        pack_reg[{cnt_idx_in_word, 3'b000} +: 8] <= bus.s_axis_tdata;
                        cnt_idx_in_word  <= cnt_idx_in_word + 5'd1;
                        cnt_idx_in_frame <= cnt_idx_in_frame + IDX_W'(1);
                        if (word_full || frame_end) begin
                            last_word <= frame_end;
                            state     <= SEND;
                        end
                    end
                end
                SEND: begin
                    if (bus.m_axis_tready) begin
                        if (last_word) begin
                            state <= DONE;
                        end else begin
                            // Clearing here keeps the unused bytes of a short final word at 0.
                            pack_reg        <= '0;
                            cnt_idx_in_word <= '0;
                            state           <= PACK;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.ap_idle       = (state == IDLE);
    assign bus.ap_ready      = (state == IDLE);
    assign bus.ap_done       = (state == DONE);
    assign bus.s_axis_tready = (state == PACK);
    assign bus.m_axis_tvalid = (state == SEND);
    assign bus.m_axis_tdata  = pack_reg;
    assign bus.m_axis_tkeep  = (state != SEND) ? 32'd0 : (last_word ? KEEP_LAST : 32'hFFFF_FFFF);
    assign bus.m_axis_tlast  = (state == SEND) && last_word;
endmodule

// File: tb/tb_pixel_packer_mono8.sv
// Directed bench for pixel_packer_mono8: an 8x8 instance and a 5x8 instance
// share one driver, selected by sel.
module tb_pixel_packer_mono8;
    logic clk = 1'b0;
    logic s_axis_resetn;
    always #5 clk = ~clk;

    pixel_packer_mono8_if bus_a ();
    pixel_packer_mono8_if bus_b ();

    pixel_packer_mono8 #(.OUT_ROWS(8), .OUT_COLS(8)) dut_a (
        .clk(clk), .s_axis_resetn(s_axis_resetn), .bus(bus_a)
    );
    pixel_packer_mono8 #(.OUT_ROWS(5), .OUT_COLS(8)) dut_b (
        .clk(clk), .s_axis_resetn(s_axis_resetn), .bus(bus_b)
    );

    logic       sel;
    logic       ap_start;
    logic       s_tvalid;
    logic [7:0] s_tdata;
    logic       m_tready;

    assign bus_a.ap_start      = !sel && ap_start;
    assign bus_a.s_axis_tvalid = !sel && s_tvalid;
    assign bus_a.s_axis_tdata  = s_tdata;
    assign bus_a.m_axis_tready = !sel && m_tready;
    assign bus_b.ap_start      = sel && ap_start;
    assign bus_b.s_axis_tvalid = sel && s_tvalid;
    assign bus_b.s_axis_tdata  = s_tdata;
    assign bus_b.m_axis_tready = sel && m_tready;

    wire         o_done   = sel ? bus_b.ap_done       : bus_a.ap_done;
    wire         o_ready  = sel ? bus_b.ap_ready      : bus_a.ap_ready;
    wire         o_idle   = sel ? bus_b.ap_idle       : bus_a.ap_idle;
    wire         o_tready = sel ? bus_b.s_axis_tready : bus_a.s_axis_tready;
    wire         o_tvalid = sel ? bus_b.m_axis_tvalid : bus_a.m_axis_tvalid;
    wire [255:0] o_tdata  = sel ? bus_b.m_axis_tdata  : bus_a.m_axis_tdata;
    wire [31:0]  o_tkeep  = sel ? bus_b.m_axis_tkeep  : bus_a.m_axis_tkeep;
    wire         o_tlast  = sel ? bus_b.m_axis_tlast  : bus_a.m_axis_tlast;

    int n_checks = 0;
    int n_errors = 0;

    logic [255:0] cap_data [4];
    logic [31:0]  cap_keep [4];
    logic         cap_last [4];
    int           cap_count;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [255:0] exp_word(input int n, input int w);
        logic [255:0] d = '0;
        for (int k = 0; k < 32; k++)
            if (32 * w + k < n) d[8*k +: 8] = 8'(32 * w + k);
        return d;
    endfunction

    task automatic start_frame();
        ap_start = 1'b1;
        check("start_ready", 256'(o_ready), 256'(1));
        @(posedge clk); #1;
        ap_start = 1'b0;
        check("start_left_idle", 256'(o_idle), 256'(0));
    endtask

    // Streams a ramp of n pixels, captures output words; gap is the percentage of
    // idle s_tvalid cycles, stall the m_tready-low cycles held on word 0.
    task automatic run_frame(input int n, input int gap, input int stall, input bit start_in_pack);
        int  pix = 0;
        int  hs31_c = -1;
        int  last_hs_c = -100;
        int  stall_left = stall;
        bit  done_seen = 1'b0;
        bit  injected = 1'b0;
        bit  first_valid = 1'b0;
        bit  s_hs, m_hs;
        cap_count = 0;
        start_frame();
        for (int c = 0; c < 2000 && !done_seen; c++) begin
            ap_start = 1'b0;
            if (start_in_pack && !injected && pix == 10) begin
                ap_start = 1'b1;
                injected = 1'b1;
                check("start_in_pack_ready", 256'(o_ready), 256'(0));
            end
            s_tvalid = (pix < n) && (gap == 0 || $urandom_range(99) >= gap);
            s_tdata  = 8'(pix);
            if (o_done) begin
                check("done_latency", 256'(c - last_hs_c), 256'(1));
                done_seen = 1'b1;
            end
            if (o_tvalid && !first_valid) begin
                first_valid = 1'b1;
                if (hs31_c >= 0) check("word0_latency", 256'(c - hs31_c), 256'(1));
            end
            m_tready = 1'b1;
            if (o_tvalid && cap_count == 0 && stall_left > 0) begin
                m_tready = 1'b0;
                stall_left--;
                check("stall_tdata", o_tdata, exp_word(n, 0));
                check("stall_s_tready", 256'(o_tready), 256'(0));
            end
            m_hs = o_tvalid && m_tready;
            s_hs = s_tvalid && o_tready;
            if (m_hs) begin
                if (cap_count < 4) begin
                    cap_data[cap_count] = o_tdata;
                    cap_keep[cap_count] = o_tkeep;
                    cap_last[cap_count] = o_tlast;
                end
                cap_count++;
                last_hs_c = c;
            end
            if (s_hs && pix == 31) hs31_c = c;
            if (!done_seen) begin
                @(posedge clk); #1;
                if (s_hs) pix++;
            end
        end
        s_tvalid = 1'b0;
        check("frame_completed", 256'(done_seen), 256'(1));
        @(posedge clk); #1;
        check("done_one_cycle", 256'(o_done), 256'(0));
        check("idle_after_done", 256'(o_idle), 256'(1));
    endtask

    task automatic verify_ramp(input string tag, input int n);
        int words = (n + 31) / 32;
        check({tag, "_word_count"}, 256'(cap_count), 256'(words));
        for (int w = 0; w < words && w < 4; w++)
            check($sformatf("%s_w%0d_data", tag, w), cap_data[w], exp_word(n, w));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_tvalid"}, 256'(bus_a.m_axis_tvalid), 256'(0));
        check({tag, "_tlast"},  256'(bus_a.m_axis_tlast),  256'(0));
        check({tag, "_tkeep"},  256'(bus_a.m_axis_tkeep),  256'(0));
        check({tag, "_tready"}, 256'(bus_a.s_axis_tready), 256'(0));
        check({tag, "_done"},   256'(bus_a.ap_done),       256'(0));
        check({tag, "_idle"},   256'(bus_a.ap_idle),       256'(1));
        check({tag, "_ready"},  256'(bus_a.ap_ready),      256'(1));
    endtask

    initial begin
        int fed;
        int stray;
        s_axis_resetn = 1'b0;
        sel = 1'b0; ap_start = 1'b0; s_tvalid = 1'b0; s_tdata = 8'd0; m_tready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("in_reset");
        check("in_reset_tdata", bus_a.m_axis_tdata, 256'd0);
        s_axis_resetn = 1'b1;
        @(posedge clk); #1;
        check_reset_outputs("after_reset");

        // 8x8 ramp, continuous valid/ready.
        run_frame(64, 0, 0, 1'b0);
        verify_ramp("cont", 64);
        check("cont_w0_low", 256'(cap_data[0][31:0]), 256'(32'h0302_0100));
        check("cont_w1_low", 256'(cap_data[1][31:0]), 256'(32'h2322_2120));
        check("cont_w0_keep", 256'(cap_keep[0]), 256'(32'hFFFF_FFFF));
        check("cont_w1_keep", 256'(cap_keep[1]), 256'(32'hFFFF_FFFF));
        check("cont_w0_last", 256'(cap_last[0]), 256'(0));
        check("cont_w1_last", 256'(cap_last[1]), 256'(1));

        // Word 0 held by 5 cycles of backpressure.
        run_frame(64, 0, 5, 1'b0);
        verify_ramp("stall", 64);
        check("stall_w1_last", 256'(cap_last[1]), 256'(1));

        // ~50% gaps on s_tvalid.
        run_frame(64, 50, 0, 1'b0);
        verify_ramp("gaps", 64);
        check("gaps_w1_keep", 256'(cap_keep[1]), 256'(32'hFFFF_FFFF));

        // 5x8 frame: short final word.
        sel = 1'b1;
        run_frame(40, 0, 0, 1'b0);
        verify_ramp("n40", 40);
        check("n40_w1_low", 256'(cap_data[1][63:0]), 256'(64'h2726_2524_2322_2120));
        check("n40_w1_pad", 256'(cap_data[1][255:64]), 256'd0);
        check("n40_w0_keep", 256'(cap_keep[0]), 256'(32'hFFFF_FFFF));
        check("n40_w1_keep", 256'(cap_keep[1]), 256'(32'h0000_00FF));
        check("n40_w0_last", 256'(cap_last[0]), 256'(0));
        check("n40_w1_last", 256'(cap_last[1]), 256'(1));
        sel = 1'b0;

        // Reset after 20 pixels of a 64-pixel frame.
        start_frame();
        fed = 0;
        while (fed < 20) begin
            s_tvalid = 1'b1;
            s_tdata  = 8'(fed);
            @(posedge clk); #1;
            fed++;
        end
        #2;
        s_axis_resetn = 1'b0;
        #1;
        check_reset_outputs("mid_reset");
        @(posedge clk); #1;
        s_axis_resetn = 1'b1;
        m_tready = 1'b1;
        stray = 0;
        for (int i = 0; i < 80; i++) begin
            @(posedge clk); #1;
            if (bus_a.m_axis_tvalid || bus_a.s_axis_tready) stray++;
        end
        s_tvalid = 1'b0;
        check("no_output_after_reset", 256'(stray), 256'd0);
        run_frame(64, 0, 0, 1'b0);
        verify_ramp("post_reset", 64);
        check("post_reset_w1_last", 256'(cap_last[1]), 256'(1));

        // ap_start during PACK ignored, then a back-to-back frame.
        run_frame(64, 0, 0, 1'b1);
        verify_ramp("b2b0", 64);
        check("b2b0_w0_last", 256'(cap_last[0]), 256'(0));
        check("b2b0_w1_last", 256'(cap_last[1]), 256'(1));
        run_frame(64, 0, 0, 1'b0);
        verify_ramp("b2b1", 64);
        check("b2b1_w0_last", 256'(cap_last[0]), 256'(0));
        check("b2b1_w1_last", 256'(cap_last[1]), 256'(1));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/pixel_packer_mono8.md
Name: pixel_packer_Mono8

Overview:
- Inverse of the Mono8 sequentializer. Accepts one 8-bit pixel per handshake from the downstream hls4ml or crop_norm stream.
- Packs 32 pixels into one 256-bit AXI-Stream word for return to the CustomLogic framegrabber output path.
- Frame-aware: a frame is OUT_ROWS*OUT_COLS pixels. A short final word is zero-padded and qualified by tkeep. The last word of a frame carries tlast.
- Uses the same ap_start/ap_done/ap_ready/ap_idle control as the rest of the chain.

Parameters:
- OUT_ROWS, default 20: rows per output frame. Set it at instantiation.
- OUT_COLS, default 20: columns per output frame. OUT_ROWS*OUT_COLS must be 1 or more. It does not need to be a multiple of 32.

Ports:
- clk  in  1  single clock.
- s_axis_resetn  in  1  asynchronous, active-low reset; the only reset.
- ap_start  in  1  starts one frame; accepted when ap_start && ap_ready.
- ap_done  out  1  one-cycle pulse after the final word handshake.
- ap_ready  out  1  block can accept ap_start.
- ap_idle  out  1  block is in IDLE.
- s_axis_tvalid  in  1  pixel valid.
- s_axis_tready  out  1  pixel accept.
- s_axis_tdata  in  8  Mono8 pixel.
- m_axis_tvalid  out  1  packed word valid.
- m_axis_tready  in  1  downstream accept.
- m_axis_tdata  out  256  packed pixels.
- m_axis_tkeep  out  32  byte qualifiers.
- m_axis_tlast  out  1  final word of frame.

Behaviour:
- Constants:
  - N = OUT_ROWS*OUT_COLS.
  - W = ceil(N/32) words per frame.
  - R = N mod 32.
- Counters:
  - cnt_idx_in_word: 5 bits.
  - cnt_idx_in_frame: $clog2(N+1) bits.
  - Both increment on an s_axis handshake. Both clear on reset and on ap_start acceptance.
- Byte order: pixel k of a word is written to tdata[8k+7:8k]. The first pixel received goes in the lowest byte, mirroring sequentializer byte-0-first order.
- Reset (asynchronous assert, synchronous release), required values:
  - FSM goes to IDLE; all counters go to 0; the pack register goes to 0.
  - m_axis_tvalid=0, m_axis_tlast=0, m_axis_tkeep=0, s_axis_tready=0, ap_done=0.
  - ap_idle=1 and ap_ready=1 during and after reset.
  - Reset mid-frame discards the partial word. No word is emitted afterwards.
- FSM states: IDLE, PACK, SEND, DONE.
- IDLE:
  - ap_idle=1, ap_ready=1, s_axis_tready=0, m_axis_tvalid=0.
  - s_axis_tvalid is ignored.
  - On ap_start: clear counters and the pack register, then go to PACK.
- PACK:
  - s_axis_tready=1, m_axis_tvalid=0, ap_ready=0, ap_idle=0.
  - On each handshake, write the pixel into byte cnt_idx_in_word.
  - Go to SEND on the handshake of the 32nd pixel of a word, or of pixel N-1 of the frame.
  - Gaps in s_axis_tvalid are allowed; the FSM stays in PACK.
- SEND:
  - m_axis_tvalid=1 and s_axis_tready=0. There is no overlap buffering.
  - The registered word appears one cycle after the completing pixel handshake, so latency is 1 cycle.
  - tdata, tkeep and tlast are held stable while m_axis_tready=0.
  - tkeep is all ones, except on the final word when R≠0: tkeep = (1<<R)-1 and unused bytes are 0.
  - tlast=1 only on the final word.
  - On the handshake: if this was the final word, go to DONE. Otherwise clear the pack register and cnt_idx_in_word, then go to PACK.
- DONE:
  - ap_done=1 for exactly one cycle. All other outputs are inactive.
  - Next state is IDLE unconditionally. A new ap_start is accepted from IDLE the following cycle.
- ap_start while not in IDLE is ignored.
- N < 32: a single word with tlast=1 and partial tkeep.
- N exactly divisible by 32: no padding word is generated.
- Pixels presented after the frame is complete are not accepted, because tready=0 outside PACK.
- Throughput: 32 pixel cycles plus 1 or more send cycles per word.

Test Plan:
- OUT_ROWS=8, OUT_COLS=8, ramp pixels 0..63, continuous valid/ready:
  - Exactly 2 words.
  - Word0 byte k=k; word1 byte k=32+k.
  - tkeep=0xFFFFFFFF on both words; tlast only on word1.
  - ap_done pulses 1 cycle after the word1 handshake.
  - Word0 tvalid is seen 1 cycle after the pixel-31 handshake.
- 5x8 frame (N=40), ramp 0..39:
  - Word1 bytes 0..7 = 32..39, bytes 8..31 = 0.
  - Word1 tkeep=0x000000FF and tlast=1.
- 64-pixel frame with m_axis_tready held low 5 cycles on word0:
  - tvalid stays high and tdata is unchanged for all 5 cycles.
  - s_axis_tready=0 during the stall.
  - No pixel is lost; word1 content is unchanged.
- Random s_axis_tvalid gaps (about 50%) on a 64-pixel ramp: output words are identical to the continuous case.
- s_axis_resetn pulsed low after 20 pixels of a 64-pixel frame:
  - All outputs return to reset values immediately, asynchronously.
  - No m_axis_tvalid appears afterwards.
  - A fresh ap_start then produces the correct 2 words.
- ap_start asserted during PACK is ignored. Two back-to-back frames started the cycle after each ap_done produce 2 words each with correct tlast and exactly one ap_done per frame.
